// File: rtl/sipo_rx_pkg.sv
// Shared types for the serial frame receiver: FSM state encoding and default word width.
// Used by sipo_shift_w and sipo_rx_ctrl (optional parity build: SIPO_RX_CTRL_PARITY_EN).
package sipo_rx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE_ENC   = 2'b00;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'b01;
  localparam logic [1:0] ST_PARITY_ENC = 2'b10;
  localparam logic [1:0] ST_STOP_ENC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE_ENC,
    SHIFT  = ST_SHIFT_ENC,
    PARITY = ST_PARITY_ENC,
    STOP   = ST_STOP_ENC
  } state_t;

endpackage

// File: rtl/sipo_shift_w.sv
// WIDTH-bit serial-in/parallel-out shift register, MSB-first: new bits enter at bit 0.
// Synchronous clear wins over shift; asynchronous active-low reset.
module sipo_shift_w
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= {r_q[WIDTH-2:0], i_serial};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial word receiver: start bit, WIDTH data bits MSB-first, optional parity, stop bit.
// Define SIPO_RX_CTRL_PARITY_EN to add the even-parity bit and the parity_err output.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             abort,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
`ifdef SIPO_RX_CTRL_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_word;
  logic             w_clr;
  logic             w_shift_en;
  logic             w_stop_ok;
  logic             w_stop_bad;

  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_out_data_next;
  logic             r_out_valid;
  logic             w_out_valid_next;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_overrun_next;

`ifdef SIPO_RX_CTRL_PARITY_EN
  logic             w_par_check;
  logic             r_par_err_pend;
  logic             r_parity_err;
  logic             w_parity_err_next;
`endif

  sipo_shift_w #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_clr),
    .i_shift_en (w_shift_en),
    .i_serial   (serial_in),
    .o_q        (w_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Abort overrides every transition; otherwise nothing moves without a sample strobe.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clr        = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
    w_par_check  = 1'b0;
`endif
    if (abort) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (!serial_in) begin
            w_state_next = SHIFT;
            w_cnt_next   = '0;
            w_clr        = 1'b1;
          end
        end
        SHIFT: begin
          w_shift_en = 1'b1;
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_RX_CTRL_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
`ifdef SIPO_RX_CTRL_PARITY_EN
        PARITY: begin
          w_par_check  = 1'b1;
          w_state_next = STOP;
        end
`endif
        STOP: begin
          w_stop_ok    = serial_in;
          w_stop_bad   = !serial_in;
          w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // A completion with the old word still pending is dropped unless it is consumed this cycle.
  always_comb begin
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_overrun_next   = 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
    w_parity_err_next = r_parity_err;
`endif
    if (w_stop_ok) begin
      if (!r_out_valid || out_ready) begin
        w_out_data_next  = w_word;
        w_out_valid_next = 1'b1;
`ifdef SIPO_RX_CTRL_PARITY_EN
        w_parity_err_next = r_par_err_pend;
`endif
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_next = 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
      w_parity_err_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_overrun_next;
    end
  end

`ifdef SIPO_RX_CTRL_PARITY_EN
  // Even parity: the line bit must equal the XOR of the received data bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_err_pend <= 1'b0;
      r_parity_err   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_par_err_pend <= 1'b0;
      end else if (w_par_check) begin
        r_par_err_pend <= (serial_in != (^w_word));
      end
      r_parity_err <= w_parity_err_next;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboarded bench for sipo_rx_ctrl; parity scenarios compile in with SIPO_RX_CTRL_PARITY_EN.
module tb_sipo_rx_ctrl;

  localparam int WIDTH = 4;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b1;
  logic             serial_in = 1'b1;
  logic             bit_en    = 1'b0;
  logic             abort     = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;
`ifdef SIPO_RX_CTRL_PARITY_EN
  logic             parity_err;
  logic             par_flip = 1'b0;
`endif

  int               vec_cnt = 0;
  int               err_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef SIPO_RX_CTRL_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  // Inputs change on the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic en, input logic sin);
    bit_en    = en;
    serial_in = sin;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    repeat (3) step(1'b0, b);
    step(1'b1, b);
  endtask

  // Returns right after the stop-bit edge, so completion effects are visible immediately.
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_b, input logic rdy_at_stop);
    logic saved;
    send_bit(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i]);
`ifdef SIPO_RX_CTRL_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    repeat (3) step(1'b0, stop_b);
    saved = out_ready;
    if (rdy_at_stop) out_ready = 1'b1;
    step(1'b1, stop_b);
    out_ready = saved;
    serial_in = 1'b1;
  endtask

  task automatic pop_check(input string name);
    vec_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: out_data=%b but scoreboard empty", name, out_data);
    end else begin
      exp_w = exp_q.pop_front();
      if (out_data !== exp_w) begin
        err_cnt++;
        $display("FAIL %s: out_data=%b expected %b", name, out_data, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec_cnt++; if (out_data !== '0) begin err_cnt++; $display("FAIL reset_data: got %b want 0000", out_data); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      err_cnt++; $display("FAIL reset_flags: frame_err=%b overrun=%b want 0 0", frame_err, overrun);
    end
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    $display("reset: done");
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    pop_check("basic_data");
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
    step(1'b0, 1'b1);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
    $display("basic: frame 1011 -> out_data=%b", out_data);
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    send_frame(4'b1011, 1'b0, 1'b0);
    vec_cnt++; if (frame_err !== 1'b1) begin err_cnt++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL ferr_valid: got %b want 0", out_valid); end
    step(1'b0, 1'b1);
    vec_cnt++; if (frame_err !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL ferr_clear: frame_err=%b busy=%b want 0 0", frame_err, busy);
    end
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b0);
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL ferr_next_valid: got %b want 1", out_valid); end
    pop_check("ferr_next_data");
    step(1'b0, 1'b1);
    $display("frame_err: bad stop then frame 0110 received");
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_first_valid: got %b want 1", out_valid); end
    send_frame(4'b0101, 1'b1, 1'b0);
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    vec_cnt++; if (out_data !== exp_q[0]) begin err_cnt++; $display("FAIL ovr_hold: got %b want %b", out_data, exp_q[0]); end
    step(1'b0, 1'b1);
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    out_ready = 1'b1;
    pop_check("ovr_data");
    step(1'b0, 1'b1);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
    out_ready = 1'b0;
    $display("overrun: 0101 dropped, 1011 kept");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    vec_cnt++; if (out_data !== exp_q[0]) begin err_cnt++; $display("FAIL b2b_first: got %b want %b", out_data, exp_q[0]); end
    exp_w = exp_q.pop_front();
    exp_q.push_back(4'b0101);
    send_frame(4'b0101, 1'b1, 1'b1);
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    pop_check("b2b_data");
    out_ready = 1'b1;
    step(1'b0, 1'b1);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    $display("back_to_back: 0101 replaced 1011 in the accept cycle");
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
    abort = 1'b1;
    step(1'b0, 1'b1);
    abort = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_idle: got %b want 0", busy); end
    exp_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b0);
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL abort_next_valid: got %b want 1", out_valid); end
    pop_check("abort_next_data");
    step(1'b0, 1'b1);
    $display("abort: partial frame discarded, 1100 received");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    exp_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b0);
    pop_check("arst_pre_data");
    send_bit(1'b0);
    send_bit(1'b1);
    #1 reset_n = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL arst_outputs: valid=%b data=%b busy=%b want 0 0000 0", out_valid, out_data, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    out_ready = 1'b1;
    exp_q.push_back(4'b0011);
    send_frame(4'b0011, 1'b1, 1'b0);
    pop_check("arst_after_data");
    step(1'b0, 1'b1);
    $display("async_reset: mid-frame reset cleared outputs, 0011 received after");
  endtask

`ifdef SIPO_RX_CTRL_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    par_flip  = 1'b0;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    vec_cnt++; if (parity_err !== 1'b0 || out_valid !== 1'b1) begin
      err_cnt++; $display("FAIL par_good: parity_err=%b valid=%b want 0 1", parity_err, out_valid);
    end
    pop_check("par_good_data");
    step(1'b0, 1'b1);
    par_flip = 1'b1;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    par_flip = 1'b0;
    vec_cnt++; if (parity_err !== 1'b1 || out_valid !== 1'b1) begin
      err_cnt++; $display("FAIL par_bad: parity_err=%b valid=%b want 1 1", parity_err, out_valid);
    end
    pop_check("par_bad_data");
    step(1'b0, 1'b1);
    vec_cnt++; if (parity_err !== 1'b0) begin err_cnt++; $display("FAIL par_clear: got %b want 0", parity_err); end
    $display("parity: good and bad parity bits on 1011");
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_async_reset();
`ifdef SIPO_RX_CTRL_PARITY_EN
    test_parity();
`endif
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_left: %0d words never delivered", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
